// File: rtl/sync_tx_arbiter.sv
// Round-robin transmit arbiter: shares one sync CDC channel among NREQ requesters,
// runs the 4-phase vi/snt handshake and returns a one-hot ack or err pulse.
module sync_tx_arbiter #(
  parameter int DATA_MSB = 7,
  parameter int NREQ     = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                           clk_tx_i,
  input  logic                           reset_i,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ*(DATA_MSB+1)-1:0]   req_data_i,
  output logic [NREQ-1:0]                ack_o,
  output logic [NREQ-1:0]                err_o,
  output logic                           busy_o,
  output logic [$clog2(NREQ)-1:0]        gnt_id_o,
  output logic                           vi_o,
  output logic [DATA_MSB:0]              indata_o,
  input  logic                           snt_i
);
  localparam int W   = DATA_MSB + 1;
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            vi_q, vi_d;
  logic            busy_q, busy_d;
  logic            to_q, to_d;
  logic [W-1:0]    indata_q, indata_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;

  logic [W-1:0]    words_s [NREQ];
  logic            win_found_s;
  logic [IDW-1:0]  win_id_s;
  int              idx_s;

  // Unpack the flattened request words.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words_s[i] = req_data_i[i*W +: W];
    end
  end

  // Scan from ptr downwards in priority so the smallest offset from ptr wins last.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    idx_s       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_s = int'(ptr_q) + k;
      if (idx_s >= NREQ) begin
        idx_s = idx_s - NREQ;
      end else begin
        idx_s = idx_s;
      end
      if (req_i[idx_s[IDW-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = idx_s[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    vi_d     = vi_q;
    to_d     = to_q;
    indata_d = indata_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    err_d    = '0;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          gnt_id_d = win_id_s;
          indata_d = words_s[win_id_s];
          vi_d     = 1'b1;
          cnt_d    = '0;
          state_d  = SEND;
        end else begin
          vi_d = 1'b0;
        end
      end
      SEND: begin
        if (snt_i) begin
          vi_d    = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q == CNT_MAX) begin
          vi_d    = 1'b0;
          err_d   = ONE_HOT0 << gnt_id_q;
          to_d    = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        vi_d = 1'b0;
        if (!snt_i) begin
          // A timed-out transfer already reported err, so it gets no ack.
          if (!to_q) begin
            ack_d = ONE_HOT0 << gnt_id_q;
          end else begin
            ack_d = '0;
          end
          to_d    = 1'b0;
          ptr_d   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
        vi_d    = 1'b0;
        to_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_tx_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      vi_q     <= 1'b0;
      busy_q   <= 1'b0;
      to_q     <= 1'b0;
      indata_q <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      vi_q     <= vi_d;
      busy_q   <= busy_d;
      to_q     <= to_d;
      indata_q <= indata_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign busy_o   = busy_q;
  assign gnt_id_o = gnt_id_q;
  assign vi_o     = vi_q;
  assign indata_o = indata_q;

endmodule

// File: tb/tb_sync_tx_arbiter.sv
// Scoreboard bench for sync_tx_arbiter: stimulus queues expected grants and
// ack/err pulses, a monitor pops and compares them as the DUT presents them.
module tb_sync_tx_arbiter;
  localparam int W    = 8;
  localparam int NREQ = 4;
  localparam int TO   = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } gexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack, err;
  logic        busy, vi, snt;
  logic [1:0]  gnt_id;
  logic [7:0]  indata;

  gexp_t       gq[$];
  logic [7:0]  dq[$];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, grant_cnt = 0, err_cnt = 0;
  int          prev_rise = 0, last_rise = 0, vi_run = 0, last_vi_len = 0;
  logic        vi_prev = 1'b0;
  logic [7:0]  cur_data = 8'h00;
  bit          snt_en = 1'b1;
  int          up_dly = 2, dn_dly = 2;
  logic [3:0]  drop_mask = 4'b0000;

  sync_tx_arbiter #(.DATA_MSB(7), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk_tx_i   (clk),
    .reset_i    (reset),
    .req_i      (req),
    .req_data_i (req_data),
    .ack_o      (ack),
    .err_o      (err),
    .busy_o     (busy),
    .gnt_id_o   (gnt_id),
    .vi_o       (vi),
    .indata_o   (indata),
    .snt_i      (snt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_g(input logic [1:0] id, input logic [7:0] data);
    gexp_t e;
    e.id   = id;
    e.data = data;
    gq.push_back(e);
  endtask

  task automatic push_d(input logic [3:0] a, input logic [3:0] e);
    dq.push_back({a, e});
  endtask

  // One cycle; requesters in drop_mask release req on their ack/err.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if ((ack[i] | err[i]) && drop_mask[i]) req[i] = 1'b0;
    end
  endtask

  task automatic wait_grant(input int target, input string name);
    int n = 0;
    while (grant_cnt < target && n < 300) begin
      tick();
      n++;
    end
    chk(name, grant_cnt >= target, 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(gq.size() == 0 && dq.size() == 0 && !busy && !vi) && n < 400);
    chk(name, (gq.size() == 0 && dq.size() == 0 && !busy && !vi), 1);
  endtask

  // sync model: raise snt up_dly cycles into vi, drop it dn_dly cycles after vi falls.
  initial begin : sync_model
    int up, dn;
    up  = 0;
    dn  = 0;
    snt = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !snt_en) begin
        snt = 1'b0; up = 0; dn = 0;
      end else if (vi && !snt) begin
        up++;
        if (up >= up_dly) begin snt = 1'b1; up = 0; end
      end else if (!vi && snt) begin
        dn++;
        if (dn >= dn_dly) begin snt = 1'b0; dn = 0; end
      end
    end
  end

  initial begin : monitor
    gexp_t      e;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      cyc++;
      if (vi && !vi_prev) begin
        grant_cnt++;
        prev_rise = last_rise;
        last_rise = cyc;
        vi_run    = 0;
        if (gq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_unexpected: got gnt_id=%0d indata=0x%0h, want no grant", gnt_id, indata);
        end else begin
          e = gq.pop_front();
          chk("grant_id", gnt_id, e.id);
          chk("grant_data", indata, e.data);
          cur_data = e.data;
        end
      end else if (busy) begin
        chk("indata_stable", indata, cur_data);
      end
      if (vi) vi_run++;
      if (!vi && vi_prev) last_vi_len = vi_run;
      if ((ack | err) != 4'b0000) begin
        if (err != 4'b0000) err_cnt++;
        if (ack != 4'b0000) chk("ack_busy_low", busy, 0);
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got ack=%b err=%b, want none", ack, err);
        end else begin
          d = dq.pop_front();
          chk("done_ack", ack, d[7:4]);
          chk("done_err", err, d[3:0]);
          chk("done_vi_low", vi, 0);
        end
      end
      vi_prev = vi;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int g0;
    reset    = 1'b1;
    req      = 4'b1111;
    req_data = 32'h44332211;

    // Reset held two cycles with every requester asking.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_vi", vi, 0);
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt_id", gnt_id, 0);
    end

    // Round-robin with req held: 0,1,2,3,0,1; requester drops mid 6th transfer.
    push_g(2'd0, 8'h11); push_d(4'b0001, 4'b0000);
    push_g(2'd1, 8'h22); push_d(4'b0010, 4'b0000);
    push_g(2'd2, 8'h33); push_d(4'b0100, 4'b0000);
    push_g(2'd3, 8'h44); push_d(4'b1000, 4'b0000);
    push_g(2'd0, 8'h11); push_d(4'b0001, 4'b0000);
    push_g(2'd1, 8'h22); push_d(4'b0010, 4'b0000);
    reset = 1'b0;
    wait_grant(6, "rr_six_grants");
    req = 4'b0000;
    wait_drain("rr_drain");

    // Single transfer; word changes after grant must not reach indata.
    drop_mask = 4'b1111;
    up_dly = 3; dn_dly = 2;
    req_data = 32'h44A52211;
    push_g(2'd2, 8'hA5); push_d(4'b0100, 4'b0000);
    g0  = grant_cnt;
    req = 4'b0100;
    wait_grant(g0 + 1, "single_grant");
    req_data[23:16] = 8'h5A;
    wait_drain("single_drain");
    chk("single_busy_after", busy, 0);
    chk("single_indata_hold", indata, 8'hA5);
    chk("single_gnt_hold", gnt_id, 2'd2);

    // ptr=3: req 0011 wraps to 0 then 1 with minimum handshake latency.
    up_dly = 1; dn_dly = 1;
    req_data = 32'h44332211;
    push_g(2'd0, 8'h11); push_d(4'b0001, 4'b0000);
    push_g(2'd1, 8'h22); push_d(4'b0010, 4'b0000);
    req = 4'b0011;
    wait_drain("wrap_drain");
    chk("min_vi_len", last_vi_len, 1);
    chk("b2b_spacing", last_rise - prev_rise, 3);

    // Timeout on requester 0, then pending requester 1 is served.
    up_dly = 2; dn_dly = 2;
    snt_en = 1'b0;
    push_g(2'd0, 8'h11); push_d(4'b0000, 4'b0001);
    push_g(2'd1, 8'h22); push_d(4'b0010, 4'b0000);
    g0  = err_cnt;
    req = 4'b0011;
    begin
      int n = 0;
      while (err_cnt == g0 && n < 100) begin
        tick();
        n++;
      end
    end
    chk("to_err_seen", err_cnt, g0 + 1);
    chk("to_vi_len", last_vi_len, TO);
    snt_en = 1'b1;
    wait_drain("to_drain");

    // snt stuck high in RELEASE: busy holds, ack only once snt falls.
    dn_dly = 20;
    push_g(2'd3, 8'h44); push_d(4'b1000, 4'b0000);
    g0  = grant_cnt;
    req = 4'b1000;
    wait_grant(g0 + 1, "stale_grant");
    begin
      int n = 0;
      while (vi && n < 50) begin
        tick();
        n++;
      end
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("stale_busy_held", busy, 1);
    end
    wait_drain("stale_drain");

    // Reset while in SEND, then the still-pending request is served again.
    dn_dly = 2;
    snt_en = 1'b0;
    push_g(2'd2, 8'h33);
    g0  = grant_cnt;
    req = 4'b0100;
    wait_grant(g0 + 1, "midrst_grant");
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_vi", vi, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_gnt_id", gnt_id, 0);
    chk("midrst_indata", indata, 0);
    push_g(2'd2, 8'h33); push_d(4'b0100, 4'b0000);
    reset  = 1'b0;
    snt_en = 1'b1;
    wait_drain("midrst_drain");

    chk("end_gq_empty", gq.size(), 0);
    chk("end_dq_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_tx_arbiter.md
# sync_tx_arbiter

Transmit-side controller that shares one `sync` CDC channel between `NREQ` requesters in the `clk_tx` domain. It picks a requester by round-robin and presents its word on `indata`. It then runs the full 4-phase `vi`/`snt` handshake with the synchronizer and returns a one-cycle `ack` (or `err` on timeout) to the requester that was served. It sits between the core-side producers and the `sync` block's `vi`, `indata` and `snt` pins.

## Interface
- `DATA_MSB`, 7, MSB of the data word; word width W = DATA_MSB+1.
- `NREQ`, 4, number of requesters (2..16).
- `TIMEOUT`, 255, maximum cycles spent in SEND waiting for `snt`=1.

- `clk_tx`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NREQ  request level per requester.
- `req_data`  in  NREQ*W  flattened words; requester i uses bits [i*W +: W].
- `ack`  out  NREQ  one-hot one-cycle pulse when a transfer completes.
- `err`  out  NREQ  one-hot one-cycle pulse when a transfer times out.
- `busy`  out  1  high whenever the state is not IDLE.
- `gnt_id`  out  $clog2(NREQ)  index of the current or last granted requester.
- `vi`  out  1  valid to `sync`.
- `indata`  out  W  data to `sync`; stable while `vi`=1 and in RELEASE.
- `snt`  in  1  sent/acknowledge from `sync`; already in the `clk_tx` domain.

## Operation
- Reset values: state IDLE, `vi`=0, `indata`=0, `ack`=0, `err`=0, `busy`=0, `gnt_id`=0, RR pointer `ptr`=0, timeout counter=0.
- **IDLE**
  - With no `req` bit set, stay in IDLE.
  - Otherwise, the winner is the first set bit scanning `ptr`, `ptr`+1, …, wrapping modulo NREQ.
  - Register the winner in `gnt_id` and its word in `indata`, set `vi`=1, clear the counter, go to SEND.
- **SEND**
  - `vi`=1.
  - If `snt` is sampled 1: `vi`←0, go to RELEASE.
  - Else, if counter = TIMEOUT-1: `vi`←0, pulse `err[gnt_id]`, set the internal flag `to`=1, go to RELEASE.
  - Else increment the counter.
- **RELEASE**
  - `vi`=0.
  - On sampling `snt`=0: pulse `ack[gnt_id]` if `to`=0, then clear `to`, set `ptr`←(`gnt_id`+1) mod NREQ, go to IDLE.
  - No timeout applies here; the block waits indefinitely for the 4-phase return to zero.
- `ptr` also advances after a timed-out transfer, so a dead requester cannot starve the others.
- `req` is sampled only in IDLE. A requester that drops `req` mid-transfer is not aborted; its `ack` still pulses.
- `req_data` is captured once, at grant. Later changes to it are ignored.
- Requesters hold `req` until they see `ack` or `err`. A `req` still high in the cycle after the pulse is treated as a new request.
- `ack` and `err` are never asserted in the same cycle. At most one bit of either is set.
- `indata` holds its value after the transfer until the next grant.
- `reset` asserted in any state forces the reset values on the next edge, including dropping `vi` mid-handshake. Recovering the `sync` block is the system's job, because it shares the same `reset`.

## Timing
- All outputs are registered.
- Edge N: IDLE samples a pending `req`. From N+1: `vi`=1, `indata` and `gnt_id` valid, `busy`=1.
- Edge M: SEND samples `snt`=1. From M+1: `vi`=0.
- Edge K: RELEASE samples `snt`=0. During K+1: `ack` is high for exactly one cycle, `busy`=0. The earliest next grant is sampled at edge K+1, with `vi` high again from K+2.
- Minimum transfer, with `snt` responding in 1 cycle: `vi` high for 1 cycle, `ack` at N+3. Back-to-back grants are spaced ≥3 cycles apart.
- `err` asserts during the cycle after edge N+TIMEOUT, together with `vi`=0. `ack` is not issued for that transfer.
- `snt` already high when SEND is entered counts as an acknowledge on the first SEND edge.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `req`=4'b1111 → `vi`, `ack`, `err`, `busy`, `gnt_id` all 0 throughout; first grant `gnt_id`=0 after release.
- **Single transfer:** `req`=4'b0100, word 2 = 8'hA5, `sync` model returns `snt` 3 cycles after `vi` and drops it 2 cycles after `vi` falls → `indata`=8'hA5 while `vi`=1; `ack`=4'b0100 pulses once; `busy` then 0.
- **Round-robin fairness:** `req`=4'b1111 held, each requester re-requesting after its ack → grant order 0,1,2,3,0,1; exactly one `ack` per transfer.
- **Pointer wrap and skip:** `ptr`=3 after serving requester 2, then `req`=4'b0011 → grant 0, then 1, with requester 3 skipped.
- **Timeout:** `TIMEOUT`=8, `snt` tied 0, `req`=4'b0001 → `vi` high 8 cycles; `err`=4'b0001 pulses once with `vi`=0; no `ack`; `ptr`=1; a pending `req`[1] is granted next.
- **Mid-operation reset, stale `snt`:**
  - `reset` in SEND → `vi`=0 next cycle and the state returns to IDLE.
  - Separately, `snt` stuck at 1 in RELEASE for 20 cycles → no `ack`, `busy`=1 held until `snt` falls, then `ack` follows.
